// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
//
// Round-robin packet scheduler that shares one uart_controller write port
// among NUM_REQ requesters. One requester owns the port for a whole packet:
// the scheduler takes the controller's write lock, forwards exactly len bytes,
// then drops the lock so the controller's other lock port can interleave at
// packet boundaries.
//
// Optional build feature (macro UART_SCHED_HEADER_EN):
//   when defined, every packet is preceded by two header bytes, 8'hA5 followed
//   by the packet length. Header bytes need only write_ready and never assert
//   ready. When undefined, only the payload is sent and no header states exist.
//
// Parameters
//   NUM_REQ         number of requesters (2..8)
//   TIMEOUT_CYCLES  consecutive idle transfer cycles before an abort (>=2)
//
// Ports
//   clock        in   system clock
//   reset        in   synchronous, active-high
//   req          in   [NUM_REQ]   requester i has a packet pending
//   len          in   [8*NUM_REQ] packet length of requester i, [8i+7:8i]
//   data         in   [8*NUM_REQ] payload byte of requester i, [8i+7:8i]
//   valid        in   [NUM_REQ]   data of requester i is valid
//   grant        out  [NUM_REQ]   one-hot current owner, 0 when idle
//   ready        out  [NUM_REQ]   byte of requester i accepted this cycle
//   abort        out  one-cycle pulse on timeout abort
//   lock_req     out  to controller write_lock_req
//   lock_res     in   from controller write_lock_res
//   write_ready  in   controller write FIFO not full
//   tx_data      out  [8] byte to controller data_in
//   tx_valid     out  to controller data_in_valid
// ---------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] len,
    input  logic [8*NUM_REQ-1:0] data,
    input  logic [NUM_REQ-1:0]   valid,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   ready,
    output logic                 abort,
    output logic                 lock_req,
    input  logic                 lock_res,
    input  logic                 write_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOCK,
        S_XFER,
`ifdef UART_SCHED_HEADER_EN
        S_HDR0,
        S_HDR1,
`endif
        S_RELEASE
    } state_t;

    state_t               r_state;
    logic [PW-1:0]        r_ptr;
    logic [PW-1:0]        r_gidx;
    logic [NUM_REQ-1:0]   r_grant;
    logic [7:0]           r_cnt;
    logic [TW-1:0]        r_timer;

    state_t               w_state_nx;
    logic [PW-1:0]        w_ptr_nx;
    logic [PW-1:0]        w_gidx_nx;
    logic [NUM_REQ-1:0]   w_grant_nx;
    logic [7:0]           w_cnt_nx;
    logic [TW-1:0]        w_timer_nx;

    logic [NUM_REQ-1:0]   w_elig;
    logic                 w_found;
    logic [PW-1:0]        w_pick;
    int                   w_idx;
    logic [7:0]           w_gdata;
    logic                 w_gvalid;
    logic                 w_greq;
    logic [7:0]           w_plen;
    logic [PW-1:0]        w_ptr_after;
    logic                 w_beat;

    // A requester with len==0 is never eligible, so a granted packet always
    // has at least one byte and cnt can never underflow.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig[i] = req[i] & (len[8*i +: 8] != 8'd0);
        end
    end

    // Round-robin search starting at r_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_pick  = PW'(w_idx);
            end
        end
    end

    assign w_gdata     = data[8*int'(r_gidx) +: 8];
    assign w_gvalid    = valid[r_gidx];
    assign w_greq      = req[r_gidx];
    assign w_plen      = len[8*int'(w_pick) +: 8];
    assign w_ptr_after = (r_gidx == LAST_IDX) ? '0 : r_gidx + 1'b1;
    assign w_beat      = w_gvalid & write_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_gidx  <= '0;
            r_grant <= '0;
            r_cnt   <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_gidx  <= w_gidx_nx;
            r_grant <= w_grant_nx;
            r_cnt   <= w_cnt_nx;
            r_timer <= w_timer_nx;
        end
    end

    // Next-state and outputs. All handshake outputs are combinational from the
    // current state and inputs so a byte is accepted in the same cycle.
    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_gidx_nx  = r_gidx;
        w_grant_nx = r_grant;
        w_cnt_nx   = r_cnt;
        w_timer_nx = r_timer;
        grant      = '0;
        ready      = '0;
        abort      = 1'b0;
        lock_req   = 1'b0;
        tx_data    = 8'd0;
        tx_valid   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_gidx_nx  = w_pick;
                    w_grant_nx = ONE_HOT0 << w_pick;
                    w_cnt_nx   = w_plen;
                    w_timer_nx = '0;
                    w_state_nx = S_LOCK;
                end
            end

            S_LOCK: begin
                grant    = r_grant;
                lock_req = 1'b1;
                if (!w_greq) begin
                    w_state_nx = S_RELEASE;
                end else if (lock_res) begin
                    w_timer_nx = '0;
`ifdef UART_SCHED_HEADER_EN
                    w_state_nx = S_HDR0;
`else
                    w_state_nx = S_XFER;
`endif
                end
            end

`ifdef UART_SCHED_HEADER_EN
            S_HDR0, S_HDR1: begin
                grant    = r_grant;
                lock_req = 1'b1;
                if (write_ready) begin
                    tx_valid   = 1'b1;
                    // r_cnt still holds the length sampled at grant here.
                    tx_data    = (r_state == S_HDR0) ? 8'hA5 : r_cnt;
                    w_timer_nx = '0;
                    w_state_nx = (r_state == S_HDR0) ? S_HDR1 : S_XFER;
                end else if (r_timer == TMO_LAST) begin
                    abort      = 1'b1;
                    w_state_nx = S_RELEASE;
                end else begin
                    w_timer_nx = r_timer + 1'b1;
                end
            end
`endif

            S_XFER: begin
                grant    = r_grant;
                lock_req = 1'b1;
                if (w_beat) begin
                    tx_valid   = 1'b1;
                    tx_data    = w_gdata;
                    ready      = r_grant;
                    w_cnt_nx   = r_cnt - 8'd1;
                    w_timer_nx = '0;
                    if (r_cnt == 8'd1) begin
                        w_state_nx = S_RELEASE;
                    end
                end else if (r_timer == TMO_LAST) begin
                    abort      = 1'b1;
                    w_state_nx = S_RELEASE;
                end else begin
                    w_timer_nx = r_timer + 1'b1;
                end
            end

            S_RELEASE: begin
                // Always spend at least one cycle here so the lock drop is
                // visible to the controller before the next grant.
                w_ptr_nx = w_ptr_after;
                if (!lock_res) begin
                    w_state_nx = S_IDLE;
                end
            end

            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

    localparam int N   = 4;
    localparam int TMO = 16;
    localparam int NV  = 16;

    logic         clock;
    logic         reset;
    logic [N-1:0] req;
    logic [31:0]  len;
    logic [31:0]  data;
    logic [N-1:0] valid;
    logic [N-1:0] grant;
    logic [N-1:0] ready;
    logic         abort;
    logic         lock_req;
    logic         lock_res;
    logic         write_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;

    int errors = 0;
    int checks = 0;

    uart_tx_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .req(req), .len(len), .data(data),
        .valid(valid), .grant(grant), .ready(ready), .abort(abort),
        .lock_req(lock_req), .lock_res(lock_res), .write_ready(write_ready),
        .tx_data(tx_data), .tx_valid(tx_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Controller model: lock_res follows lock_req one cycle late.
    always @(posedge clock) begin
        if (reset) lock_res <= 1'b0;
        else       lock_res <= lock_req;
    end

    typedef struct packed {
        logic [3:0]  req;
        logic [31:0] len;
        logic [31:0] data;
        logic [3:0]  valid;
        logic        wr;
        logic [3:0]  grant;
        logic        lock;
        logic        txv;
        logic [7:0]  txd;
        logic [3:0]  ready;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic [3:0] r, input logic [31:0] l, input logic [31:0] d,
                                input logic [3:0] v, input logic w, input logic [3:0] g,
                                input logic lk, input logic tv, input logic [7:0] td,
                                input logic [3:0] rd);
        vec_t x;
        x.req = r; x.len = l; x.data = d; x.valid = v; x.wr = w;
        x.grant = g; x.lock = lk; x.txv = tv; x.txd = td; x.ready = rd;
        return x;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; valid = '0; len = '0; data = '0; write_ready = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, gap, nbytes, g0_cyc, g0_tx, ab_cnt, ab_at, next_g, seen_g1, got;
        logic seen_ab, post_ab;

        // Single packet on requester 1, then len==0 skip (2 skipped, 3 granted).
        vecs[0]  = mk(4'b0010, 32'h0000_0300, 32'h0000_1100, 4'b0010, 1, 4'b0000, 0, 0, 8'h00, 4'b0000);
        vecs[1]  = mk(4'b0010, 32'h0000_0300, 32'h0000_1100, 4'b0010, 1, 4'b0010, 1, 0, 8'h00, 4'b0000);
        vecs[2]  = mk(4'b0010, 32'h0000_0300, 32'h0000_1100, 4'b0010, 1, 4'b0010, 1, 0, 8'h00, 4'b0000);
        vecs[3]  = mk(4'b0010, 32'h0000_0300, 32'h0000_1100, 4'b0010, 1, 4'b0010, 1, 1, 8'h11, 4'b0010);
        vecs[4]  = mk(4'b0010, 32'h0000_0900, 32'h0000_2200, 4'b0010, 1, 4'b0010, 1, 1, 8'h22, 4'b0010);
        vecs[5]  = mk(4'b0010, 32'h0000_0900, 32'h0000_3300, 4'b0010, 1, 4'b0010, 1, 1, 8'h33, 4'b0010);
        vecs[6]  = mk(4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, 1, 4'b0000, 0, 0, 8'h00, 4'b0000);
        vecs[7]  = mk(4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, 1, 4'b0000, 0, 0, 8'h00, 4'b0000);
        vecs[8]  = mk(4'b1100, 32'h0200_0000, 32'hA1EE_0000, 4'b1100, 1, 4'b0000, 0, 0, 8'h00, 4'b0000);
        vecs[9]  = mk(4'b1100, 32'h0200_0000, 32'hA1EE_0000, 4'b1100, 1, 4'b1000, 1, 0, 8'h00, 4'b0000);
        vecs[10] = mk(4'b1100, 32'h0200_0000, 32'hA1EE_0000, 4'b1100, 1, 4'b1000, 1, 0, 8'h00, 4'b0000);
        vecs[11] = mk(4'b1100, 32'h0200_0000, 32'hA1EE_0000, 4'b1100, 1, 4'b1000, 1, 1, 8'hA1, 4'b1000);
        vecs[12] = mk(4'b1100, 32'h0200_0000, 32'hB2EE_0000, 4'b1100, 1, 4'b1000, 1, 1, 8'hB2, 4'b1000);
        vecs[13] = mk(4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, 1, 4'b0000, 0, 0, 8'h00, 4'b0000);
        vecs[14] = mk(4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, 1, 4'b0000, 0, 0, 8'h00, 4'b0000);
        vecs[15] = mk(4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, 1, 4'b0000, 0, 0, 8'h00, 4'b0000);

        do_reset();
        #1;
        chk("rst_grant", 0, 32'(grant), 0);
        chk("rst_lock_req", 0, 32'(lock_req), 0);
        chk("rst_tx_valid", 0, 32'(tx_valid), 0);
        chk("rst_ready", 0, 32'(ready), 0);
        chk("rst_abort", 0, 32'(abort), 0);

        // Idle with no requests.
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            #1;
            chk("idle_grant", c, 32'(grant), 0);
            chk("idle_lock_req", c, 32'(lock_req), 0);
            chk("idle_tx_valid", c, 32'(tx_valid), 0);
        end

        // Vector table.
        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            req = vecs[i].req; len = vecs[i].len; data = vecs[i].data;
            valid = vecs[i].valid; write_ready = vecs[i].wr;
            #1;
            chk("tbl_grant", i, 32'(grant), 32'(vecs[i].grant));
            chk("tbl_lock_req", i, 32'(lock_req), 32'(vecs[i].lock));
            chk("tbl_tx_valid", i, 32'(tx_valid), 32'(vecs[i].txv));
            chk("tbl_ready", i, 32'(ready), 32'(vecs[i].ready));
            chk("tbl_abort", i, 32'(abort), 0);
            if (vecs[i].txv) chk("tbl_tx_data", i, 32'(tx_data), 32'(vecs[i].txd));
        end

        // Round robin: all four request single-byte packets.
        do_reset();
        req = 4'b1111; len = 32'h0101_0101; valid = 4'b1111; data = 32'h4342_4140;
        n = 0; gap = 0;
        for (int c = 0; c < 200 && n < 5; c++) begin
            @(negedge clock);
            #1;
            if (tx_valid) begin
                chk("rr_grant", n, 32'(grant), 32'(4'b0001 << (n % 4)));
                chk("rr_tx_data", n, 32'(tx_data), 32'h40 + 32'(n % 4));
                chk("rr_ready", n, 32'(ready), 32'(grant));
                if (n > 0) chk("rr_release_gap", n, 32'(gap >= 1), 1);
                gap = 0;
                n++;
            end else if (grant == 4'b0000) begin
                gap++;
            end
        end
        chk("rr_packets", 0, 32'(n), 5);
        req = '0;

        // Backpressure: write_ready low on cycles 2..5 of a 4-byte packet.
        do_reset();
        req = 4'b0001; len = 32'h0000_0004; valid = 4'b0001; data = 32'h0000_00C0;
        got = 0;
        for (int c = 0; c < 20 && got == 0; c++) begin
            @(negedge clock);
            #1;
            if (tx_valid) got = 1;
        end
        chk("bp_first_beat", 0, 32'(got), 1);
        chk("bp_byte", 0, 32'(tx_data), 32'hC0);
        nbytes = 1;
        for (int c = 2; c <= 12; c++) begin
            @(negedge clock);
            write_ready = (c >= 2 && c <= 5) ? 1'b0 : 1'b1;
            data = 32'(8'hC0 + 8'(nbytes));
            #1;
            if (c >= 2 && c <= 5) begin
                chk("bp_stall_tx_valid", c, 32'(tx_valid), 0);
                chk("bp_stall_ready", c, 32'(ready), 0);
                chk("bp_stall_lock", c, 32'(lock_req), 1);
            end else if (tx_valid) begin
                chk("bp_byte", nbytes, 32'(tx_data), 32'hC0 + 32'(nbytes));
                chk("bp_ready", nbytes, 32'(ready), 32'b0001);
                nbytes++;
            end
            if (grant == 4'b0000 && nbytes == 4) req = '0;
        end
        chk("bp_byte_count", 0, 32'(nbytes), 4);
        chk("bp_end_lock_req", 0, 32'(lock_req), 0);
        chk("bp_end_grant", 0, 32'(grant), 0);

        // Timeout: requester 0 never supplies data; requester 1 is next.
        do_reset();
        req = 4'b0011; len = 32'h0000_0101; valid = 4'b0010; data = 32'h0000_5B00;
        g0_cyc = 0; g0_tx = 0; ab_cnt = 0; ab_at = 0; next_g = 0; seen_g1 = 0;
        seen_ab = 1'b0; post_ab = 1'b0;
        for (int c = 0; c < 150 && seen_g1 == 0; c++) begin
            @(negedge clock);
            #1;
            if (post_ab) begin
                chk("tmo_lock_dropped", 0, 32'(lock_req), 0);
                chk("tmo_grant_dropped", 0, 32'(grant), 0);
                req[0] = 1'b0;
                post_ab = 1'b0;
            end
            if (grant == 4'b0001) begin
                g0_cyc++;
                if (tx_valid) g0_tx++;
            end
            if (abort) begin
                ab_cnt++;
                ab_at = g0_cyc;
                seen_ab = 1'b1;
                post_ab = 1'b1;
            end
            if (seen_ab && !abort && grant != 4'b0000 && next_g == 0) next_g = 32'(grant);
            if (grant == 4'b0010 && tx_valid) begin
                chk("tmo_next_data", 0, 32'(tx_data), 32'h5B);
                seen_g1 = 1;
            end
        end
        chk("tmo_abort_count", 0, 32'(ab_cnt), 1);
        chk("tmo_abort_cycle", 0, 32'(ab_at), TMO + 2);
        chk("tmo_no_tx", 0, 32'(g0_tx), 0);
        chk("tmo_next_grant", 0, 32'(next_g), 32'b0010);
        chk("tmo_next_served", 0, 32'(seen_g1), 1);
        req = '0;

        // Reset in the middle of a packet.
        do_reset();
        req = 4'b0001; len = 32'h0000_0005; valid = 4'b0001; data = 32'h0000_0077;
        got = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            @(negedge clock);
            #1;
            if (tx_valid) got++;
        end
        chk("mid_beats", 0, 32'(got), 2);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("mid_rst_grant", 0, 32'(grant), 0);
        chk("mid_rst_lock_req", 0, 32'(lock_req), 0);
        chk("mid_rst_tx_valid", 0, 32'(tx_valid), 0);
        chk("mid_rst_ready", 0, 32'(ready), 0);
        chk("mid_rst_abort", 0, 32'(abort), 0);
        @(negedge clock);
        reset = 1'b0;
        req = '0;
        @(negedge clock);
        #1;
        chk("mid_after_grant", 0, 32'(grant), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
